// File: rtl/serial_frame_pkg.sv
// Shared definitions for the serial demux link, used by both transmitter and receiver.
package serial_frame_pkg;

    localparam int PN_W     = 2;
    localparam int LEN_W    = 4;
    localparam int HDR_BITS = PN_W + LEN_W;
    localparam int DATA_W   = 2**LEN_W - 1;
    localparam int SR_W     = HDR_BITS + DATA_W;

    // Level the line rests at between frames and during the stop bit.
    localparam logic LINE_IDLE = 1'b1;

    // The state names the bit currently on the line.
    typedef enum logic [2:0] {
        IDLE,
        START,
        HDR,
        DATA,
        STOP
    } state_t;

endpackage

// File: rtl/serial_frame_tx_if.sv
// Request/ack bus plus serial line of the frame transmitter.
interface serial_frame_tx_if;
    import serial_frame_pkg::*;

    logic              req;
    logic [PN_W-1:0]   pn;
    logic [LEN_W-1:0]  len;
    logic [DATA_W-1:0] data;
    logic              ready;
    logic              sOut;
    logic              busy;
    logic              done;

    modport master (
        output req, pn, len, data,
        input  ready, sOut, busy, done
    );

    modport slave (
        input  req, pn, len, data,
        output ready, sOut, busy, done
    );

endinterface

// File: rtl/serial_frame_tx_piso.sv
// Loadable parallel-in/serial-out shift register; shifts right, LSB leaves first.
module piso_shift #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic         i_shift,
    input  logic [W-1:0] i_data,
    output logic         o_lsb
);

    logic [W-1:0] r_sr;

    // Load wins over shift; zeros fill from the top as bits are consumed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sr <= '0;
        end else if (i_load) begin
            r_sr <= i_data;
        end else if (i_shift) begin
            r_sr <= {1'b0, r_sr[W-1:1]};
        end
    end

    assign o_lsb = r_sr[0];

endmodule

// File: rtl/serial_frame_tx.sv
// Serial frame transmitter: start, port, length, payload, stop on an idle-high line.
module serial_frame_tx
    import serial_frame_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    serial_frame_tx_if.slave  bus
);

    state_t             r_state;
    state_t             w_next;
    logic [LEN_W-1:0]   r_cnt;
    logic [LEN_W-1:0]   r_len;
    logic               r_sOut;
    logic               w_accept;
    logic               w_shift;
    logic               w_lsb;
    logic [SR_W-1:0]    w_loadWord;

    assign bus.ready  = (r_state == IDLE) || (r_state == STOP);
    assign bus.busy   = (r_state != IDLE);
    assign bus.done   = (r_state == STOP);
    assign bus.sOut   = r_sOut;
    assign w_accept   = bus.req && bus.ready;
    assign w_loadWord = {bus.data, bus.len, bus.pn};

    piso_shift #(.W(SR_W)) u_piso (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_accept),
        .i_shift (w_shift),
        .i_data  (w_loadWord),
        .o_lsb   (w_lsb)
    );

    // State register; reset drops straight back to IDLE so busy clears without a clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; the shifter advances whenever the next line bit comes from it.
    always_comb begin
        w_next  = r_state;
        w_shift = 1'b0;
        case (r_state)
            IDLE:    if (w_accept) w_next = START;
            START:   w_next = HDR;
            HDR:     if (r_cnt == '0) w_next = (r_len != '0) ? DATA : STOP;
            DATA:    if (r_cnt == '0) w_next = STOP;
            STOP:    w_next = w_accept ? START : IDLE;
            default: w_next = IDLE;
        endcase
        w_shift = (w_next == HDR) || (w_next == DATA);
    end

    // Segment counter: header length on leaving START, payload length on leaving HDR.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (r_state == START) begin
            r_cnt <= LEN_W'(HDR_BITS - 1);
        end else if ((r_state == HDR) && (r_cnt == '0)) begin
            if (r_len != '0) r_cnt <= r_len - LEN_W'(1);
        end else if (((r_state == HDR) || (r_state == DATA)) && (r_cnt != '0)) begin
            r_cnt <= r_cnt - LEN_W'(1);
        end
    end

    // Payload length is held for the whole frame since the input need not stay stable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_len <= '0;
        end else if (w_accept) begin
            r_len <= bus.len;
        end
    end

    // Registered line driver; the level is chosen by the state being entered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sOut <= LINE_IDLE;
        end else begin
            case (w_next)
                START:     r_sOut <= 1'b0;
                HDR, DATA: r_sOut <= w_lsb;
                default:   r_sOut <= LINE_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_frame_tx.sv
// Scoreboard bench for serial_frame_tx: each accepted frame queues its expected line bits.
module tb_serial_frame_tx;
    import serial_frame_pkg::*;

    typedef struct packed {
        logic s;
        logic d;
    } expBit_t;

    logic    clk;
    logic    rst;
    expBit_t expQ[$];
    expBit_t e;
    int      testsRun;
    int      testsFailed;

    serial_frame_tx_if bus();

    serial_frame_tx dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point; every check in the bench passes through here.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Present a frame, wait (bounded) for it to be taken, then queue its expected bits.
    task automatic applyStimulus(input logic [PN_W-1:0] pnV, input logic [LEN_W-1:0] lenV,
                                 input logic [DATA_W-1:0] dataV, input bit holdReq);
        int waited;
        @(negedge clk);
        bus.req  = 1'b1;
        bus.pn   = pnV;
        bus.len  = lenV;
        bus.data = dataV;
        waited   = 0;
        while (!bus.ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.ready) begin
            checkOutput("readyTimeout", 32'd0, 32'd1);
            bus.req = 1'b0;
        end else begin
            @(posedge clk);
            expQ.push_back('{s: 1'b0, d: 1'b0});
            for (int i = 0; i < PN_W; i++)  expQ.push_back('{s: pnV[i], d: 1'b0});
            for (int i = 0; i < LEN_W; i++) expQ.push_back('{s: lenV[i], d: 1'b0});
            for (int i = 0; i < int'(lenV); i++) expQ.push_back('{s: dataV[i], d: 1'b0});
            expQ.push_back('{s: 1'b1, d: 1'b1});
            #1;
            bus.pn   = PN_W'($urandom);
            bus.len  = LEN_W'($urandom);
            bus.data = DATA_W'($urandom);
            if (!holdReq) bus.req = 1'b0;
        end
    endtask

    // Let all queued bits drain and the line go idle, with a cycle budget.
    task automatic waitIdle();
        int waited;
        waited = 0;
        while ((expQ.size() != 0 || bus.busy) && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("drainTimeout", 32'(expQ.size() != 0 || bus.busy), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    // Line monitor: pop one expected bit per busy cycle, otherwise expect a quiet line.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.busy) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpectedBusy", 32'd1, 32'd0);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("sOut", 32'(bus.sOut), 32'(e.s));
                    checkOutput("done", 32'(bus.done), 32'(e.d));
                    checkOutput("readyBusy", 32'(bus.ready), 32'(e.d));
                end
            end else begin
                checkOutput("idleLine", 32'(bus.sOut), 32'd1);
                checkOutput("idleDone", 32'(bus.done), 32'd0);
                checkOutput("idleReady", 32'(bus.ready), 32'd1);
                checkOutput("idlePending", 32'(expQ.size()), 32'd0);
            end
        end
    end

    // Main sequence of directed and swept frames.
    initial begin
        testsRun    = 0;
        testsFailed = 0;
        rst      = 1'b1;
        bus.req  = 1'b0;
        bus.pn   = '0;
        bus.len  = '0;
        bus.data = '0;
        repeat (3) @(negedge clk);
        checkOutput("rstSOut", 32'(bus.sOut), 32'd1);
        checkOutput("rstBusy", 32'(bus.busy), 32'd0);
        checkOutput("rstDone", 32'(bus.done), 32'd0);
        checkOutput("rstReady", 32'(bus.ready), 32'd1);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // pn=2, len=3, data=101: line 0,0,1,1,1,0,0,1,0,1,1
        applyStimulus(2'b10, 4'd3, 15'b101, 1'b0);
        waitIdle();

        // Empty payload: 8-cycle frame
        applyStimulus(2'b01, 4'd0, 15'h7FFF, 1'b0);
        waitIdle();

        // Longest payload, all ones
        applyStimulus(2'b11, 4'd15, 15'h7FFF, 1'b0);
        waitIdle();

        // Back-to-back frames with req held high
        applyStimulus(2'b00, 4'd2, 15'b10, 1'b1);
        applyStimulus(2'b01, 4'd2, 15'b01, 1'b1);
        applyStimulus(2'b10, 4'd2, 15'b11, 1'b1);
        applyStimulus(2'b11, 4'd2, 15'b00, 1'b0);
        waitIdle();

        // Request pulsed during the header with different inputs is ignored
        applyStimulus(2'b01, 4'd5, 15'b10110, 1'b0);
        repeat (3) @(negedge clk);
        bus.req  = 1'b1;
        bus.pn   = 2'b10;
        bus.len  = 4'd9;
        bus.data = 15'h5A5A;
        @(negedge clk);
        bus.req  = 1'b0;
        waitIdle();

        // Sweep every port and length, alternating gapped and back-to-back frames
        for (int p = 0; p < 4; p++) begin
            for (int l = 0; l < 16; l++) begin
                applyStimulus(PN_W'(p), LEN_W'(l), DATA_W'($urandom), (l % 3) != 2);
            end
            bus.req = 1'b0;
            waitIdle();
        end

        // Reset in the middle of the payload
        applyStimulus(2'b11, 4'd12, DATA_W'($urandom), 1'b0);
        repeat (10) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("midRstSOut", 32'(bus.sOut), 32'd1);
        checkOutput("midRstBusy", 32'(bus.busy), 32'd0);
        checkOutput("midRstDone", 32'(bus.done), 32'd0);
        checkOutput("midRstReady", 32'(bus.ready), 32'd1);
        expQ.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        applyStimulus(2'b10, 4'd7, 15'b1011001, 1'b0);
        waitIdle();

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
